// File: rtl/hard_mem_1rw_arb_ctrl_pkg.sv
// rtl/hard_mem_1rw_arb_ctrl_pkg.sv - shared types for the 1RW SRAM arbiter/controller
package hard_mem_arb_pkg;

   localparam int mem_width_gp      = 64;
   localparam int mem_els_gp        = 512;
   localparam int mem_addr_width_gp = $clog2(mem_els_gp);
   localparam int mem_mask_width_gp = mem_width_gp >> 3;

   typedef enum logic {INIT, READY} state_e;

   typedef struct packed {
      logic                         v;
      logic                         w;
      logic [mem_addr_width_gp-1:0] addr;
      logic [mem_width_gp-1:0]      data;
      logic [mem_mask_width_gp-1:0] mask;
   } mem_cmd_s;

endpackage

// File: rtl/hard_mem_1rw_arb_ctrl_rr_arb.sv
// rtl/hard_mem_1rw_arb_ctrl_rr_arb.sv - round-robin arbiter, pointer advances past each accepted winner
module hard_mem_1rw_rr_arb #(
   parameter int num_req_p = 2,
   localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [num_req_p-1:0]   elig_i,
   input  logic                   accept_i,
   output logic [num_req_p-1:0]   grant_o,
   output logic                   grant_v_o,
   output logic [id_width_lp-1:0] id_o
);

   logic [id_width_lp-1:0] rr_ptr_r;
   logic [id_width_lp-1:0] idx;

   // Scan farthest-first so the candidate closest to rr_ptr_r is the last one to win.
   always_comb begin
      grant_o   = '0;
      grant_v_o = 1'b0;
      id_o      = '0;
      idx       = '0;
      for (int off = num_req_p - 1; off >= 0; off--) begin
         idx = id_width_lp'((int'(rr_ptr_r) + off) % num_req_p);
         if (elig_i[idx]) begin
            id_o      = idx;
            grant_v_o = 1'b1;
         end
      end
      if (grant_v_o) grant_o[id_o] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         rr_ptr_r <= '0;
      else if (accept_i && grant_v_o)
         rr_ptr_r <= id_width_lp'((int'(id_o) + 1) % num_req_p);
   end

endmodule

// File: rtl/hard_mem_1rw_arb_ctrl.sv
// rtl/hard_mem_1rw_arb_ctrl.sv - clears a shared 1RW byte-masked SRAM, then arbitrates requesters onto it
module hard_mem_1rw_arb_ctrl
   import hard_mem_arb_pkg::*;
#(
   parameter int width_p   = mem_width_gp,
   parameter int els_p     = mem_els_gp,
   parameter int num_req_p = 2,
   localparam int mask_width_lp = width_p >> 3,
   localparam int addr_width_lp = $clog2(els_p),
   localparam int id_width_lp   = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [num_req_p-1:0]               req_v_i,
   input  logic [num_req_p-1:0]               req_w_i,
   input  logic [num_req_p*addr_width_lp-1:0] req_addr_i,
   input  logic [num_req_p*width_p-1:0]       req_data_i,
   input  logic [num_req_p*mask_width_lp-1:0] req_mask_i,
   output logic [num_req_p-1:0]               req_ready_o,
   output logic                               rdata_v_o,
   output logic [width_p-1:0]                 rdata_o,
   output logic [id_width_lp-1:0]             rdata_id_o,
   input  logic                               rdata_yumi_i,
   output logic                               init_done_o,
   output logic                               mem_v_o,
   output logic                               mem_w_o,
   output logic [addr_width_lp-1:0]           mem_addr_o,
   output logic [width_p-1:0]                 mem_data_o,
   output logic [mask_width_lp-1:0]           mem_mask_o,
   input  logic [width_p-1:0]                 mem_data_i
);

   state_e                   state_r;
   logic [addr_width_lp-1:0] init_cnt_r;
   logic                     init_done_r, rd_inflight_r, buf_v_r;
   logic [id_width_lp-1:0]   rd_id_r, buf_id_r, gnt_id;
   logic [width_p-1:0]       buf_r;
   logic [num_req_p-1:0]     elig, gnt;
   logic                     gnt_v, rd_ok, rd_grant;
   mem_cmd_s                 cmd;

   logic [addr_width_lp-1:0] addr_arr [num_req_p];
   logic [width_p-1:0]       data_arr [num_req_p];
   logic [mask_width_lp-1:0] mask_arr [num_req_p];

   for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
      assign addr_arr[i] = req_addr_i[i*addr_width_lp +: addr_width_lp];
      assign data_arr[i] = req_data_i[i*width_p +: width_p];
      assign mask_arr[i] = req_mask_i[i*mask_width_lp +: mask_width_lp];
   end

   // A read may only win if its return slot is free next cycle.
   assign rd_ok = ~(rd_inflight_r | buf_v_r) | rdata_yumi_i;
   assign elig  = (state_r == READY) ? (req_v_i & (req_w_i | {num_req_p{rd_ok}})) : '0;

   hard_mem_1rw_rr_arb #(.num_req_p(num_req_p)) arb (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .elig_i   (elig),
      .accept_i (state_r == READY),
      .grant_o  (gnt),
      .grant_v_o(gnt_v),
      .id_o     (gnt_id)
   );

   assign rd_grant = gnt_v & ~req_w_i[gnt_id];

   always_comb begin
      cmd = '0;
      if (state_r == INIT) begin
         cmd.v    = 1'b1;
         cmd.w    = 1'b1;
         cmd.addr = init_cnt_r;
         cmd.mask = '1;
      end else if (gnt_v) begin
         cmd.v    = 1'b1;
         cmd.w    = req_w_i[gnt_id];
         cmd.addr = addr_arr[gnt_id];
         cmd.data = data_arr[gnt_id];
         cmd.mask = mask_arr[gnt_id];
      end
   end

   assign req_ready_o = gnt;
   assign mem_v_o     = cmd.v;
   assign mem_w_o     = cmd.w;
   assign mem_addr_o  = cmd.addr;
   assign mem_data_o  = cmd.data;
   assign mem_mask_o  = cmd.mask;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r       <= INIT;
         init_cnt_r    <= '0;
         init_done_r   <= 1'b0;
         rd_inflight_r <= 1'b0;
         buf_v_r       <= 1'b0;
      end else begin
         if (state_r == INIT) begin
            init_cnt_r <= init_cnt_r + 1'b1;
            if (init_cnt_r == addr_width_lp'(els_p - 1)) begin
               state_r     <= READY;
               init_done_r <= 1'b1;
            end
         end
         rd_inflight_r <= rd_grant;
         if (rd_inflight_r && !rdata_yumi_i)
            buf_v_r <= 1'b1;
         else if (rdata_yumi_i)
            buf_v_r <= 1'b0;
      end
   end

   // SRAM output is only valid the cycle after the read, so an unconsumed return is parked here.
   always_ff @(posedge clk_i) begin
      if (rd_grant) rd_id_r <= gnt_id;
      if (rd_inflight_r && !rdata_yumi_i) begin
         buf_r    <= mem_data_i;
         buf_id_r <= rd_id_r;
      end
   end

   assign rdata_v_o   = rd_inflight_r | buf_v_r;
   assign rdata_o     = buf_v_r ? buf_r : mem_data_i;
   assign rdata_id_o  = buf_v_r ? buf_id_r : rd_id_r;
   assign init_done_o = init_done_r;

   a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      !(rdata_yumi_i && !rdata_v_o));
   a_grant_onehot0: assert property (@(posedge clk_i) $onehot0(req_ready_o));

endmodule

// File: tb/tb_hard_mem_1rw_arb_ctrl.sv
// tb/tb_hard_mem_1rw_arb_ctrl.sv - self-checking bench for hard_mem_1rw_arb_ctrl
module tb_hard_mem_1rw_arb_ctrl;

   localparam int W  = 64;
   localparam int E  = 512;
   localparam int N  = 2;
   localparam int AW = 9;
   localparam int MW = 8;
   localparam int IW = 1;

   logic            clk_i = 1'b0;
   logic            reset_i;
   logic [N-1:0]    req_v_i, req_w_i, req_ready_o;
   logic [N*AW-1:0] req_addr_i;
   logic [N*W-1:0]  req_data_i;
   logic [N*MW-1:0] req_mask_i;
   logic            rdata_v_o, rdata_yumi_i, init_done_o;
   logic [W-1:0]    rdata_o;
   logic [IW-1:0]   rdata_id_o;
   logic            mem_v_o, mem_w_o;
   logic [AW-1:0]   mem_addr_o;
   logic [W-1:0]    mem_data_o, mem_data_i;
   logic [MW-1:0]   mem_mask_o;

   int checks = 0;
   int errors = 0;

   hard_mem_1rw_arb_ctrl #(.width_p(W), .els_p(E), .num_req_p(N)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .req_v_i(req_v_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i),
      .req_data_i(req_data_i), .req_mask_i(req_mask_i), .req_ready_o(req_ready_o),
      .rdata_v_o(rdata_v_o), .rdata_o(rdata_o), .rdata_id_o(rdata_id_o),
      .rdata_yumi_i(rdata_yumi_i), .init_done_o(init_done_o),
      .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i)
   );

   always #5 clk_i = ~clk_i;

   // SRAM stand-in: output garbles on writes, so only the cycle after a read is trustworthy.
   logic [W-1:0] sram [E];
   logic [W-1:0] sram_q;
   always @(posedge clk_i) begin
      if (mem_v_o) begin
         if (mem_w_o) begin
            for (int b = 0; b < MW; b++)
               if (mem_mask_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_data_o[b*8 +: 8];
            sram_q <= {$urandom(), $urandom()};
         end else begin
            sram_q <= sram[mem_addr_o];
         end
      end
   end
   assign mem_data_i = sram_q;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1);
   end

   function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] d,
                                          input logic [MW-1:0] m);
      logic [W-1:0] r = o;
      for (int b = 0; b < MW; b++) if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   task automatic idle();
      req_v_i = '0; req_w_i = '0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
      rdata_yumi_i = 1'b0;
   endtask

   task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                          input logic [W-1:0] d, input logic [MW-1:0] m);
      req_v_i[i] = 1'b1;
      req_w_i[i] = w;
      req_addr_i[i*AW +: AW] = a;
      req_data_i[i*W +: W] = d;
      req_mask_i[i*MW +: MW] = m;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic reset_and_init();
      reset_i = 1'b1;
      idle();
      tick();
      reset_i = 1'b0;
      for (int k = 0; k < E + 4 && !init_done_o; k++) tick();
      checks++;
      if (init_done_o !== 1'b1) begin
         errors++;
         $display("FAIL init_wait: init_done_o=%b required 1 within %0d cycles", init_done_o, E + 4);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1;
      idle();
      tick();
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== '0 || rdata_v_o !== 1'b0 || init_done_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: ready=%b rdata_v=%b init_done=%b required 00 0 0",
                  req_ready_o, rdata_v_o, init_done_o);
      end
      tick();
      reset_i = 1'b0;
      for (int k = 0; k < E; k++) begin
         req_v_i = '1;
         req_w_i = N'($urandom());
         @(negedge clk_i);
         checks++;
         if (mem_v_o !== 1'b1 || mem_w_o !== 1'b1 || mem_addr_o !== AW'(k) || mem_data_o !== '0 ||
             mem_mask_o !== '1 || req_ready_o !== '0 || init_done_o !== 1'b0) begin
            errors++;
            $display("FAIL init_clear[%0d]: v=%b w=%b addr=%0d data=%h mask=%h ready=%b done=%b required 1 1 %0d 0 ff 00 0",
                     k, mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o, req_ready_o, init_done_o, k);
         end
         tick();
      end
      idle();
      @(negedge clk_i);
      checks++;
      if (init_done_o !== 1'b1 || mem_v_o !== 1'b0) begin
         errors++;
         $display("FAIL init_done: init_done=%b mem_v=%b required 1 0", init_done_o, mem_v_o);
      end
   endtask

   task automatic test_write_read();
      tick();
      idle();
      set_req(0, 1'b1, AW'(5), 64'h1122334455667788, 8'h0F);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 2'b01 || mem_w_o !== 1'b1 || mem_addr_o !== AW'(5) || mem_mask_o !== 8'h0F) begin
         errors++;
         $display("FAIL wr_grant: ready=%b w=%b addr=%0d mask=%h required 01 1 5 0f",
                  req_ready_o, mem_w_o, mem_addr_o, mem_mask_o);
      end
      tick();
      idle();
      set_req(1, 1'b0, AW'(5), '0, '0);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 2'b10) begin
         errors++;
         $display("FAIL rd_grant: ready=%b required 10", req_ready_o);
      end
      tick();
      idle();
      rdata_yumi_i = rdata_v_o;
      @(negedge clk_i);
      checks++;
      if (rdata_v_o !== 1'b1 || rdata_o !== 64'h0000000055667788 || rdata_id_o !== 1'b1) begin
         errors++;
         $display("FAIL masked_read: v=%b data=%h id=%0d required 1 0000000055667788 1",
                  rdata_v_o, rdata_o, rdata_id_o);
      end
      tick();
      idle();
      @(negedge clk_i);
      checks++;
      if (rdata_v_o !== 1'b0) begin
         errors++;
         $display("FAIL read_consumed: rdata_v=%b required 0", rdata_v_o);
      end
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 8; c++) begin
         tick();
         idle();
         rdata_yumi_i = rdata_v_o;
         set_req(0, 1'b0, AW'(16 + c), '0, '0);
         set_req(1, 1'b0, AW'(24 + c), '0, '0);
         @(negedge clk_i);
         checks++;
         if (req_ready_o !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL b2b_grant[%0d]: ready=%b required %b", c, req_ready_o,
                     (c % 2 == 0) ? 2'b01 : 2'b10);
         end
         if (c >= 1) begin
            checks++;
            if (rdata_v_o !== 1'b1 || rdata_id_o !== IW'((c - 1) % 2) || rdata_o !== '0) begin
               errors++;
               $display("FAIL b2b_return[%0d]: v=%b id=%0d data=%h required 1 %0d 0",
                        c, rdata_v_o, rdata_id_o, rdata_o, (c - 1) % 2);
            end
         end
      end
      tick();
      idle();
      rdata_yumi_i = rdata_v_o;
      @(negedge clk_i);
      checks++;
      if (rdata_v_o !== 1'b1 || rdata_id_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_last: v=%b id=%0d required 1 1", rdata_v_o, rdata_id_o);
      end
      tick();
      idle();
   endtask

   task automatic test_stall();
      logic [W-1:0] d1;
      logic [W-1:0] ds [5];
      d1 = {$urandom(), $urandom()};
      set_req(1, 1'b1, AW'(7), d1, 8'hFF);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 2'b10) begin
         errors++;
         $display("FAIL stall_setup_wr: ready=%b required 10", req_ready_o);
      end
      tick();
      idle();
      set_req(0, 1'b0, AW'(7), '0, '0);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 2'b01) begin
         errors++;
         $display("FAIL stall_setup_rd: ready=%b required 01", req_ready_o);
      end
      for (int s = 0; s < 5; s++) begin
         tick();
         idle();
         ds[s] = {$urandom(), $urandom()};
         set_req(0, 1'b0, AW'(7), '0, '0);
         set_req(1, 1'b1, AW'(7), ds[s], 8'hFF);
         @(negedge clk_i);
         checks++;
         if (rdata_v_o !== 1'b1 || rdata_o !== d1 || rdata_id_o !== 1'b0 || req_ready_o !== 2'b10) begin
            errors++;
            $display("FAIL stall_hold[%0d]: v=%b data=%h id=%0d ready=%b required 1 %h 0 10",
                     s, rdata_v_o, rdata_o, rdata_id_o, req_ready_o, d1);
         end
      end
      tick();
      idle();
      rdata_yumi_i = 1'b1;
      set_req(0, 1'b0, AW'(7), '0, '0);
      set_req(1, 1'b1, AW'(7), {$urandom(), $urandom()}, 8'hFF);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 2'b01 || rdata_o !== d1) begin
         errors++;
         $display("FAIL stall_release: ready=%b data=%h required 01 %h", req_ready_o, rdata_o, d1);
      end
      tick();
      idle();
      rdata_yumi_i = rdata_v_o;
      @(negedge clk_i);
      checks++;
      if (rdata_v_o !== 1'b1 || rdata_id_o !== 1'b0 || rdata_o !== ds[4]) begin
         errors++;
         $display("FAIL stall_resume: v=%b id=%0d data=%h required 1 0 %h",
                  rdata_v_o, rdata_id_o, rdata_o, ds[4]);
      end
      tick();
      idle();
   endtask

   task automatic test_reset_midop();
      set_req(0, 1'b0, AW'(3), '0, '0);
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 2'b01) begin
         errors++;
         $display("FAIL midop_grant: ready=%b required 01", req_ready_o);
      end
      tick();
      idle();
      reset_i = 1'b1;
      @(negedge clk_i);
      checks++;
      if (rdata_v_o !== 1'b1) begin
         errors++;
         $display("FAIL midop_inflight: rdata_v=%b required 1", rdata_v_o);
      end
      tick();
      reset_i = 1'b0;
      @(negedge clk_i);
      checks++;
      if (rdata_v_o !== 1'b0 || mem_v_o !== 1'b1 || mem_w_o !== 1'b1 || mem_addr_o !== '0 ||
          init_done_o !== 1'b0) begin
         errors++;
         $display("FAIL midop_restart: rdata_v=%b v=%b w=%b addr=%0d done=%b required 0 1 1 0 0",
                  rdata_v_o, mem_v_o, mem_w_o, mem_addr_o, init_done_o);
      end
      for (int k = 0; k < E + 4 && !init_done_o; k++) tick();
      checks++;
      if (init_done_o !== 1'b1) begin
         errors++;
         $display("FAIL midop_init: init_done=%b required 1", init_done_o);
      end
   endtask

   typedef struct {
      logic [IW-1:0] id;
      logic [W-1:0]  data;
   } ret_t;

   task automatic test_random();
      logic [W-1:0]  ref_mem [E];
      ret_t          q [$];
      int            wait_cnt [N];
      logic [N-1:0]  elig;
      logic          rd_free, exp_v;
      logic [AW-1:0] a;
      int            starve_bad;
      for (int i = 0; i < E; i++) ref_mem[i] = '0;
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      reset_and_init();
      for (int cyc = 0; cyc < 10000; cyc++) begin
         if (cyc != 0) tick();
         idle();
         for (int i = 0; i < N; i++) begin
            a = ($urandom() % 8 == 0) ? AW'(E - 1) : AW'($urandom() % 16);
            if ($urandom() % 4 != 0)
               set_req(i, 1'($urandom()), a, {$urandom(), $urandom()}, MW'($urandom()));
         end
         rdata_yumi_i = rdata_v_o && ($urandom() % 3 != 0);
         @(negedge clk_i);
         exp_v = (q.size() != 0);
         checks++;
         if (rdata_v_o !== exp_v || (exp_v && (rdata_o !== q[0].data || rdata_id_o !== q[0].id))) begin
            errors++;
            $display("FAIL rand_return[%0d]: v=%b id=%0d data=%h required v=%b id=%0d data=%h", cyc,
                     rdata_v_o, rdata_id_o, rdata_o, exp_v, exp_v ? q[0].id : '0, exp_v ? q[0].data : '0);
         end
         rd_free = (q.size() == 0) || rdata_yumi_i;
         for (int i = 0; i < N; i++) elig[i] = req_v_i[i] && (req_w_i[i] || rd_free);
         checks++;
         if (!$onehot0(req_ready_o) || (req_ready_o & ~elig) != '0 || (elig != '0 && req_ready_o == '0) ||
             mem_v_o !== (req_ready_o != '0)) begin
            errors++;
            $display("FAIL rand_grant[%0d]: ready=%b mem_v=%b eligible=%b", cyc, req_ready_o, mem_v_o, elig);
         end
         starve_bad = 0;
         for (int i = 0; i < N; i++) begin
            wait_cnt[i] = (elig[i] && !req_ready_o[i]) ? wait_cnt[i] + 1 : 0;
            if (wait_cnt[i] > N - 1) starve_bad++;
         end
         checks++;
         if (starve_bad != 0) begin
            errors++;
            $display("FAIL rand_starve[%0d]: %0d requesters waited beyond %0d grants, required 0",
                     cyc, starve_bad, N - 1);
         end
         if (rdata_yumi_i && q.size() != 0) void'(q.pop_front());
         for (int i = 0; i < N; i++) begin
            if (req_ready_o[i]) begin
               a = req_addr_i[i*AW +: AW];
               if (req_w_i[i])
                  ref_mem[a] = merge(ref_mem[a], req_data_i[i*W +: W], req_mask_i[i*MW +: MW]);
               else
                  q.push_back('{id: IW'(i), data: ref_mem[a]});
            end
         end
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         idle();
         rdata_yumi_i = rdata_v_o;
         @(negedge clk_i);
         if (q.size() != 0) begin
            checks++;
            if (rdata_v_o !== 1'b1 || rdata_o !== q[0].data || rdata_id_o !== q[0].id) begin
               errors++;
               $display("FAIL rand_drain: v=%b id=%0d data=%h required 1 %0d %h",
                        rdata_v_o, rdata_id_o, rdata_o, q[0].id, q[0].data);
            end
            if (rdata_yumi_i) void'(q.pop_front());
         end
      end
      tick();
      idle();
      @(negedge clk_i);
      checks++;
      if (rdata_v_o !== 1'b0 || q.size() != 0) begin
         errors++;
         $display("FAIL rand_final: rdata_v=%b pending=%0d required 0 0", rdata_v_o, q.size());
      end
   endtask

   initial begin
      reset_i = 1'b1;
      idle();
      test_reset();
      test_write_read();
      test_back_to_back();
      test_stall();
      test_reset_midop();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
